line_mem_bridge: RTL and testbench



---
 rtl/line_mem_bridge.sv | 180 ++++++++++++++++++
 tb/tb_line_mem_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_bridge.sv
// ============================================================================
// line_mem_bridge
// Bridges the data cache's 128-bit line memory port onto a 32-bit valid/ready
// word memory bus. Line requests are queued in a small in-order FIFO, each is
// serialised into four word beats, and read lines are reassembled and pulsed
// back to the cache.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_req_*       line request from cache (single-cycle strobe, no ready)
//   mem_res_*       assembled read line + one-cycle completion pulse
//   ext_req_*       word beat request (valid/ready)
//   ext_res_*       in-order read word return (no backpressure)
//   busy            FIFO non-empty or a transfer in progress
//   err_overflow    sticky: a request was dropped on a full FIFO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module line_mem_bridge #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [127:0]      mem_req_data,
  input  logic              mem_req_rw,
  input  logic              mem_req_valid,
  output logic [127:0]      mem_res_data,
  output logic              mem_res_ready,
  output logic              ext_req_valid,
  input  logic              ext_req_ready,
  output logic [ADDR_W-1:0] ext_req_addr,
  output logic              ext_req_we,
  output logic [31:0]       ext_req_wdata,
  input  logic              ext_res_valid,
  input  logic [31:0]       ext_res_rdata,
  output logic              busy,
  output logic              err_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_W = ADDR_W - 4;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RD, RESP} state_t;

  // Request FIFO storage (data path only, no reset needed)
  logic [TAG_W-1:0] fifo_tag  [FIFO_DEPTH];
  logic             fifo_rw   [FIFO_DEPTH];
  logic [127:0]     fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  state_t       state;
  logic [TAG_W-1:0] tag;
  logic         rw;
  logic [127:0] data;
  logic [1:0]   beat;
  logic [2:0]   rcnt;
  logic [127:0] line;

  logic         pop, push, accept, capture;
  logic [2:0]   rcnt_next;
  logic [127:0] line_next;

  // Line offset bits are not part of the request.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, mem_req_addr[3:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A pop on the same edge frees a slot, so a push into a full FIFO succeeds.
  assign pop    = (state == IDLE) && (count != '0);
  assign push   = mem_req_valid && ((count != FULL_CNT) || pop);
  assign accept = (state == SEND) && ext_req_ready;

  // Words are only captured while a read transfer is in flight; anything
  // arriving in IDLE or during a write is stray and dropped.
  assign capture = ext_res_valid && (rcnt != 3'd4) &&
                   (((state == SEND) && !rw) || (state == WAIT_RD));
  assign rcnt_next = rcnt + {2'b00, capture};

  always_comb begin
    line_next = line;
    if (capture) line_next[{rcnt[1:0], 5'b0} +: 32] = ext_res_rdata;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag[wr_ptr]  <= mem_req_addr[ADDR_W-1:4];
      fifo_rw[wr_ptr]   <= mem_req_rw;
      fifo_data[wr_ptr] <= mem_req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      state         <= IDLE;
      tag           <= '0;
      rw            <= 1'b0;
      data          <= '0;
      beat          <= '0;
      rcnt          <= '0;
      line          <= '0;
      mem_res_ready <= 1'b0;
      mem_res_data  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (mem_req_valid && !push) err_overflow <= 1'b1;

      mem_res_ready <= 1'b0;
      if (capture) begin
        line <= line_next;
        rcnt <= rcnt_next;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            tag   <= fifo_tag[rd_ptr];
            rw    <= fifo_rw[rd_ptr];
            data  <= fifo_data[rd_ptr];
            beat  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            beat <= beat + 1'b1;
            if (beat == 2'd3) begin
              if (rw) begin
                state <= IDLE;
              end else if (rcnt_next == 3'd4) begin
                state         <= RESP;
                mem_res_ready <= 1'b1;
                mem_res_data  <= line_next;
              end else begin
                state <= WAIT_RD;
              end
            end
          end
        end
        WAIT_RD: begin
          if (rcnt_next == 3'd4) begin
            state         <= RESP;
            mem_res_ready <= 1'b1;
            mem_res_data  <= line_next;
          end
        end
        RESP: begin
          rcnt  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat outputs derive purely from registers, so they hold while stalled.
  assign ext_req_valid = (state == SEND);
  assign ext_req_addr  = ext_req_valid ? {tag, beat, 2'b00} : '0;
  assign ext_req_we    = ext_req_valid && rw;
  assign ext_req_wdata = (ext_req_valid && rw) ? data[{beat, 5'b0} +: 32] : '0;
  assign busy          = (count != '0) || (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_line_mem_bridge.sv
// ============================================================================
// tb_line_mem_bridge
// Scoreboard bench for line_mem_bridge: expected word beats and read lines are
// queued when requests are issued and compared as the DUT produces them. A
// behavioural word memory answers read beats one cycle after acceptance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic [127:0] mem_res_data;
  logic         mem_res_ready;
  logic         ext_req_valid;
  logic         ext_req_ready;
  logic [31:0]  ext_req_addr;
  logic         ext_req_we;
  logic [31:0]  ext_req_wdata;
  logic         ext_res_valid;
  logic [31:0]  ext_res_rdata;
  logic         busy;
  logic         err_overflow;

  line_mem_bridge #(.FIFO_DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
    .mem_res_data(mem_res_data), .mem_res_ready(mem_res_ready),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_addr(ext_req_addr), .ext_req_we(ext_req_we),
    .ext_req_wdata(ext_req_wdata), .ext_res_valid(ext_res_valid),
    .ext_res_rdata(ext_res_rdata), .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  beat_t        beat_q[$];
  logic [127:0] line_q[$];
  logic [31:0]  rd_q[$];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [31:0]  ext_mem [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int res_pulses = 0;

  // Bench control knobs (changed at posedge+1, consumed at posedge+2)
  bit resp_en    = 1'b1;
  bit hold_all   = 1'b0;
  int stall_left = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : init_word(a);
  endfunction

  // Word memory: record beats accepted at the coming edge.
  always @(negedge clk) begin
    if (!rst && ext_req_valid && ext_req_ready) begin
      if (ext_req_we) ext_mem[ext_req_addr] = ext_req_wdata;
      else            rd_q.push_back(ext_rd(ext_req_addr));
    end
  end

  // Response and ready drivers, after DUT outputs have settled.
  always @(posedge clk) begin
    #2;
    if (resp_en && rd_q.size() > 0) begin
      ext_res_valid = 1'b1;
      ext_res_rdata = rd_q.pop_front();
    end else begin
      ext_res_valid = 1'b0;
      ext_res_rdata = '0;
    end
    if (hold_all) begin
      ext_req_ready = 1'b0;
    end else if (stall_left > 0 && ext_req_valid && ext_req_addr[3:2] == 2'd2) begin
      ext_req_ready = 1'b0;
      stall_left--;
    end else begin
      ext_req_ready = 1'b1;
    end
  end

  // Scoreboard monitor.
  bit          prev_stall = 1'b0;
  logic [65:0] prev_vec;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("beat_hold", {ext_req_valid, ext_req_we, ext_req_addr, ext_req_wdata}, prev_vec);
      prev_stall = ext_req_valid && !ext_req_ready;
      prev_vec   = {ext_req_valid, ext_req_we, ext_req_addr, ext_req_wdata};
      if (ext_req_valid && ext_req_ready) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("beat", {ext_req_addr, ext_req_we, ext_req_wdata}, {e.addr, e.we, e.wdata});
        end
      end
      if (mem_res_ready) begin
        res_pulses++;
        if (line_q.size() == 0) chk("res_unexpected", 1, 0);
        else                    chk("res_line", mem_res_data, line_q.pop_front());
      end
    end
  end

  // Drives one request cycle starting at posedge+1; returns at next posedge+1.
  task automatic req(input logic [31:0] a, input logic rw, input logic [127:0] d,
                     input bit accepted);
    logic [31:0]  base;
    logic [31:0]  w;
    logic [127:0] ln;
    mem_req_addr  = a;
    mem_req_rw    = rw;
    mem_req_data  = d;
    mem_req_valid = 1'b1;
    if (accepted) begin
      base = {a[31:4], 4'b0000};
      ln   = '0;
      for (int i = 0; i < 4; i++) begin
        if (rw) begin
          w = d[32*i +: 32];
          ref_mem[base + 32'(4*i)] = w;
          beat_q.push_back('{base + 32'(4*i), 1'b1, w});
        end else begin
          ln[32*i +: 32] = ref_rd(base + 32'(4*i));
          beat_q.push_back('{base + 32'(4*i), 1'b0, 32'h0});
        end
      end
      if (!rw) line_q.push_back(ln);
    end
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    mem_req_data  = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy || beat_q.size() != 0 || line_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, (n >= 300), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int pulses0;
    rst = 1'b1;
    mem_req_addr = '0; mem_req_data = '0; mem_req_rw = 1'b0; mem_req_valid = 1'b0;
    ext_req_ready = 1'b1; ext_res_valid = 1'b0; ext_res_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_data",  mem_res_data, 0);
    chk("rst_res_ready", mem_res_ready, 0);
    chk("rst_ext_valid", ext_req_valid, 0);
    chk("rst_ext_addr",  ext_req_addr, 0);
    chk("rst_overflow",  err_overflow, 0);
    chk("rst_busy",      busy, 0);
    rst = 1'b0;
    cycles(2);

    // Single read with latency measurement.
    req(32'h0000_1238, 1'b0, '0, 1'b1);
    cnt = 1;
    while (!mem_res_ready && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("rd_latency", cnt, 7);
    wait_done("t1_done");
    chk("t1_pulses", res_pulses, 1);

    // Write-back then refill on consecutive cycles.
    req(32'h0000_2000, 1'b1, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, 1'b1);
    req(32'h0000_5000, 1'b0, '0, 1'b1);
    wait_done("t2_done");
    chk("t2_pulses", res_pulses, 2);
    chk("t2_overflow", err_overflow, 0);

    // Read after write to the same line sees the written data.
    req(32'h0000_8004, 1'b1, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b1);
    req(32'h0000_8000, 1'b0, '0, 1'b1);
    wait_done("t3_done");

    // Ready low for three cycles on beat 2.
    stall_left = 3;
    req(32'h0000_9000, 1'b0, '0, 1'b1);
    wait_done("t4_done");
    chk("t4_stall_used", stall_left, 0);
    stall_left = 3;
    req(32'h0000_9100, 1'b1, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 1'b1);
    wait_done("t4w_done");
    chk("t4w_stall_used", stall_left, 0);

    // Overflow: first request held in SEND, then three back-to-back requests.
    hold_all = 1'b1;
    req(32'h0000_3000, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
    cnt = 0;
    while (!ext_req_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("t5_in_send", ext_req_valid, 1);
    req(32'h0000_4000, 1'b0, '0, 1'b1);
    req(32'h0000_4010, 1'b0, '0, 1'b1);
    req(32'h0000_4020, 1'b0, '0, 1'b0);
    chk("t5_overflow", err_overflow, 1);
    hold_all = 1'b0;
    wait_done("t5_done");
    chk("t5_overflow_sticky", err_overflow, 1);

    // Reset in WAIT_RD after two of four words.
    pulses0 = res_pulses;
    resp_en = 1'b0;
    req(32'h0000_6000, 1'b0, '0, 1'b1);
    cnt = 0;
    while (beat_q.size() != 0 && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("t6_beats_sent", beat_q.size(), 0);
    resp_en = 1'b1;
    cycles(2);
    resp_en = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    void'(line_q.pop_front());
    resp_en = 1'b1;
    cycles(6);
    chk("t6_no_pulse", res_pulses, pulses0);
    chk("t6_busy", busy, 0);
    chk("t6_res_data", mem_res_data, 0);
    chk("t6_overflow_clr", err_overflow, 0);
    chk("t6_ext_valid", ext_req_valid, 0);

    // Spurious response in IDLE, then a clean read.
    rd_q.push_back(32'hDEAD_BEEF);
    cycles(3);
    req(32'h0000_7000, 1'b0, '0, 1'b1);
    wait_done("t7_done");
    chk("t7_pulses", res_pulses, pulses0 + 1);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
